// File: rtl/aes_pkg.sv
// Shared AES definitions for the execute-stage AES blocks.
//
// Contents:
//   word_t / state_t  - one 32-bit column word, and a 4-column state
//                       (word i is column i, bits [31:24] hold row 0)
//   ark_state_e       - control FSM encoding of add_round_key_stage
//   SBOX              - forward AES S-box
//   sbox_lookup()     - byte substitution through SBOX
//   rcon_for()        - round constant for key-schedule round 1..10, 0 otherwise
package aes_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [3:0] state_t;

  typedef enum logic {
    ST_IDLE = 1'b0,   // no key loaded, nothing accepted
    ST_RUN  = 1'b1    // key loaded, accepting states
  } ark_state_e;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant used when deriving round key r from round key r-1.
  function automatic logic [7:0] rcon_for(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/key_expand_step.sv
// One step of the AES-128 key schedule (combinational).
//
// Ports:
//   rk       in   current round key, word i = w[i]
//   rcon     in   round constant for the key being produced
//   rk_next  out  following round key
//
// Contains its own four S-box lookups so the key path never competes
// with the data path for an S-box.
module key_expand_step
  import aes_pkg::*;
(
  input  state_t     rk,
  input  logic [7:0] rcon,
  output state_t     rk_next
);

  word_t rot;
  word_t sub;
  word_t t;

  always_comb begin
    rot = {rk[3][23:0], rk[3][31:24]};
    sub = {sbox_lookup(rot[31:24]), sbox_lookup(rot[23:16]),
           sbox_lookup(rot[15:8]),  sbox_lookup(rot[7:0])};
    t   = sub ^ {rcon, 24'h0};
    // Each word chains off the previously produced one.
    rk_next[0] = rk[0] ^ t;
    rk_next[1] = rk[1] ^ rk_next[0];
    rk_next[2] = rk[2] ^ rk_next[1];
    rk_next[3] = rk[3] ^ rk_next[2];
  end

endmodule

// File: rtl/add_round_key_stage.sv
// AES AddRoundKey execute stage with on-the-fly AES-128 key expansion.
//
// Each accepted state is XORed with the current round key; the round key
// then advances one schedule step, so consecutive states of one block see
// round keys 0..NUM_ROUNDS in order.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   key_load, key_in      one-cycle pulse loading the cipher key as round key 0
//   in_valid/in_ready     input handshake, state_in
//   out_valid/out_ready   output handshake, state_out/out_round/out_last
//   dbg_state             current control FSM state
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Valid never waits on ready; ready may depend on valid. While
// out_valid && !out_ready the output fields are held stable.
//
// Build option: ARK_KEY_RETAIN_EN keeps the cipher key in a base-key
// register and rewinds to it after round NUM_ROUNDS, so successive blocks
// need no reload. Without it the stage returns to IDLE after round
// NUM_ROUNDS and waits for the next key_load.
module add_round_key_stage
  import aes_pkg::*;
#(
  parameter int regSize    = 32,
  parameter int vecSize    = 4,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              key_load,
  input  logic [vecSize-1:0][regSize-1:0]   key_in,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [vecSize-1:0][regSize-1:0]   state_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [vecSize-1:0][regSize-1:0]   state_out,
  output logic [3:0]                        out_round,
  output logic                              out_last,
  output ark_state_e                        dbg_state
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  ark_state_e state_q, state_d;
  state_t     rk_q, rk_d;
  state_t     rk_step;
  logic [3:0] round_q, round_d;
  logic [3:0] round_inc;
  logic [7:0] rcon_next;
  logic       accept;
  logic       last_round;

`ifdef ARK_KEY_RETAIN_EN
  state_t     base_q;
`endif

  assign round_inc  = round_q + 4'd1;
  assign rcon_next  = rcon_for(round_inc);
  assign last_round = (round_q == LAST_ROUND);

  // key_load blocks acceptance so it can win over an input in the same cycle.
  assign in_ready  = (state_q == ST_RUN) && !key_load && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state_q;

  key_expand_step u_key_expand_step (
    .rk      (rk_q),
    .rcon    (rcon_next),
    .rk_next (rk_step)
  );

  // Control state, round counter and round-key register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rk_q    <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    if (key_load) begin
      state_d = ST_RUN;
      rk_d    = key_in;
      round_d = '0;
    end else if (accept) begin
      if (last_round) begin
        round_d = '0;
`ifdef ARK_KEY_RETAIN_EN
        rk_d    = base_q;
`else
        rk_d    = rk_step;
        state_d = ST_IDLE;
`endif
      end else begin
        round_d = round_inc;
        rk_d    = rk_step;
      end
    end
  end

`ifdef ARK_KEY_RETAIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
    end else if (key_load) begin
      base_q <= key_in;
    end
  end
`endif

  // Output register: an accept overwrites it even while it is being drained,
  // so a steady stream flows at one state per cycle with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      state_out <= '0;
      out_round <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      state_out <= state_in ^ rk_q;
      out_round <= round_q;
      out_last  <= last_round;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
